// File: rtl/pwm_meter_pkg.sv
// Shared types and constants for the PWM period/duty meter.
package pwm_meter_pkg;

    // Measurement FSM states.
    typedef enum logic [1:0] {
        WAIT_RISE = 2'd0,
        HIGH      = 2'd1,
        LOW       = 2'd2
    } meter_state_t;

    // Quotient bits produced by the duty divider, one per cycle.
    localparam int DIV_ITER = 8;
    // Cycles from the accepting rise detect to the valid pulse.
    localparam int DIV_LAT  = 9;

endpackage

// File: rtl/pwm_duty_div.sv
// Restoring divider producing an 8-bit quotient, one bit per cycle.
// The caller guarantees dividend[CTR_LEN+7:8] < divisor, so the quotient
// always fits in 8 bits. busy covers the iterations and the done cycle.
module pwm_duty_div
    import pwm_meter_pkg::*;
#(
    parameter int CTR_LEN = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [CTR_LEN+7:0]   dividend,
    input  logic [CTR_LEN-1:0]   divisor,
    output logic                 busy,
    output logic                 done,
    output logic [7:0]           quotient
);

    localparam int ITER_W = $clog2(DIV_LAT);

    logic              run_q;
    logic [ITER_W-1:0] iter_q;
    logic [CTR_LEN-1:0] rem_q;
    logic [CTR_LEN-1:0] div_q;
    logic [7:0]        low_q;
    logic [7:0]        q_work_q;
    logic [7:0]        quot_q;
    logic [CTR_LEN:0]  trial;
    logic              fits;

    // Trial subtraction for the current bit: shift in the next dividend bit.
    always_comb begin
        trial = {rem_q, low_q[7]};
        fits  = (trial >= {1'b0, div_q});
    end

    // Iteration sequencer; the published quotient only changes on the last step.
    always_ff @(posedge clk) begin
        if (rst) begin
            run_q    <= 1'b0;
            iter_q   <= '0;
            rem_q    <= '0;
            div_q    <= '0;
            low_q    <= '0;
            q_work_q <= '0;
            quot_q   <= '0;
        end else if (start && !run_q) begin
            run_q    <= 1'b1;
            iter_q   <= ITER_W'(DIV_ITER);
            rem_q    <= dividend[CTR_LEN+7:8];
            low_q    <= dividend[7:0];
            div_q    <= divisor;
            q_work_q <= '0;
        end else if (run_q) begin
            if (iter_q != '0) begin
                // Remainder stays below the divisor, so the low bits of the
                // difference are exact even when trial's top bit is set.
                rem_q    <= fits ? (trial[CTR_LEN-1:0] - div_q) : trial[CTR_LEN-1:0];
                low_q    <= {low_q[6:0], 1'b0};
                q_work_q <= {q_work_q[6:0], fits};
                iter_q   <= iter_q - 1'b1;
                if (iter_q == ITER_W'(1)) begin
                    quot_q <= {q_work_q[6:0], fits};
                end
            end else begin
                run_q <= 1'b0;
            end
        end
    end

    assign busy     = run_q;
    assign done     = run_q && (iter_q == '0);
    assign quotient = quot_q;

endmodule

// File: rtl/pwm_meter.sv
// PWM input meter: measures period and high time of an asynchronous PWM
// input in clk cycles and reports duty = floor(high_time*256/period).
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   WAIT_RISE | no reference edge yet (reset or timeout); falls ignored
//   HIGH      | counting from a rise detect, waiting for the fall
//   LOW       | high time captured, waiting for the rise closing the period
module pwm_meter
    import pwm_meter_pkg::*;
#(
    parameter int CTR_LEN     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pwm_in,
    output logic [CTR_LEN-1:0] period,
    output logic [CTR_LEN-1:0] high_time,
    output logic [7:0]         duty,
    output logic               valid,
    output logic               overrun,
    output logic               timeout,
    output logic               level
);

    localparam logic [CTR_LEN-1:0] CNT_MAX  = '1;
    localparam logic [CTR_LEN-1:0] CNT_LAST = {{(CTR_LEN-1){1'b1}}, 1'b0};
    localparam logic [CTR_LEN-1:0] CNT_ONE  = {{(CTR_LEN-1){1'b0}}, 1'b1};

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES:0]   fill_q;
    logic                   edge_q;
    logic                   rise_det;
    logic                   fall_det;
    logic [CTR_LEN-1:0]     cnt_q;
    meter_state_t           state_q, state_d;
    logic                   latch_high, take_period, to_event;
    logic                   accept;
    logic [CTR_LEN-1:0]     high_cand_q;
    logic [CTR_LEN-1:0]     period_pend_q, high_pend_q;
    logic [CTR_LEN-1:0]     period_hold_q, high_hold_q;
    logic                   overrun_q, timeout_q, level_q;
    logic                   div_busy, div_done;
    logic [7:0]             div_quot;

    // Synchronizer, edge-detect flop, and a fill marker so the reset value of
    // the chain never looks like an edge when the pin is already high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            fill_q <= '0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            fill_q <= {fill_q[SYNC_STAGES-1:0], 1'b1};
            edge_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign rise_det = fill_q[SYNC_STAGES] &&  sync_q[SYNC_STAGES-1] && !edge_q;
    assign fall_det = fill_q[SYNC_STAGES] && !sync_q[SYNC_STAGES-1] &&  edge_q;

    // Cycle counter: restarts at 1 on each rise detect, saturates at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (rise_det) begin
            cnt_q <= CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= WAIT_RISE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and capture strobes; an expected edge beats the timeout.
    always_comb begin
        state_d     = state_q;
        latch_high  = 1'b0;
        take_period = 1'b0;
        to_event    = 1'b0;
        case (state_q)
            WAIT_RISE: begin
                if (rise_det) state_d = HIGH;
            end
            HIGH: begin
                if (fall_det) begin
                    latch_high = 1'b1;
                    state_d    = LOW;
                end else if (cnt_q >= CNT_LAST) begin
                    to_event = 1'b1;
                    state_d  = WAIT_RISE;
                end
            end
            LOW: begin
                if (rise_det) begin
                    take_period = 1'b1;
                    state_d     = HIGH;
                end else if (cnt_q >= CNT_LAST) begin
                    to_event = 1'b1;
                    state_d  = WAIT_RISE;
                end
            end
            default: state_d = WAIT_RISE;
        endcase
    end

    assign accept = take_period && !div_busy;

    // Candidate capture, result staging and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            high_cand_q   <= '0;
            period_pend_q <= '0;
            high_pend_q   <= '0;
            period_hold_q <= '0;
            high_hold_q   <= '0;
            overrun_q     <= 1'b0;
            timeout_q     <= 1'b0;
            level_q       <= 1'b0;
        end else begin
            if (latch_high) high_cand_q <= cnt_q;
            if (accept) begin
                period_pend_q <= cnt_q;
                high_pend_q   <= high_cand_q;
            end
            if (div_done) begin
                period_hold_q <= period_pend_q;
                high_hold_q   <= high_pend_q;
            end
            overrun_q <= take_period && div_busy;
            if (to_event) begin
                timeout_q <= 1'b1;
                level_q   <= sync_q[SYNC_STAGES-1];
            end else if (div_done) begin
                timeout_q <= 1'b0;
            end
        end
    end

    pwm_duty_div #(
        .CTR_LEN (CTR_LEN)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (accept),
        .dividend ({high_cand_q, 8'h00}),
        .divisor  (cnt_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quot)
    );

    // Staged operands are presented in the valid cycle itself, then held.
    assign period    = div_done ? period_pend_q : period_hold_q;
    assign high_time = div_done ? high_pend_q   : high_hold_q;
    assign duty      = div_quot;
    assign valid     = div_done;
    assign overrun   = overrun_q;
    assign timeout   = timeout_q;
    assign level     = level_q;

endmodule

// File: tb/tb_pwm_meter.sv
// Directed bench for pwm_meter (CTR_LEN=9 so the timeout path is reachable).
// Pin changes are driven 1 ns after a rising edge; a pin change in cycle c is
// rise/fall-detected in cycle c+2 and the resulting valid appears in c+11.
module tb_pwm_meter;

    localparam int CTR_LEN = 9;

    logic               clk = 1'b0;
    logic               rst;
    logic               pwm_in;
    logic [CTR_LEN-1:0] period;
    logic [CTR_LEN-1:0] high_time;
    logic [7:0]         duty;
    logic               valid;
    logic               overrun;
    logic               timeout;
    logic               level;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int n_valid, n_ovr, valid_cyc, last_rise, rise_p, tout_cyc;
    logic [CTR_LEN-1:0] v_period, v_high;
    logic [7:0]         v_duty;
    logic               tout_lvl;

    pwm_meter #(
        .CTR_LEN     (CTR_LEN),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .pwm_in    (pwm_in),
        .period    (period),
        .high_time (high_time),
        .duty      (duty),
        .valid     (valid),
        .overrun   (overrun),
        .timeout   (timeout),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (valid === 1'b1) begin
            n_valid++;
            valid_cyc = cyc;
            v_period  = period;
            v_high    = high_time;
            v_duty    = duty;
        end
        if (overrun === 1'b1) n_ovr++;
    endtask

    task automatic wave(input int h, input int p, input int n);
        for (int k = 0; k < n; k++) begin
            for (int i = 0; i < p; i++) begin
                if (i == 0) begin
                    pwm_in    = 1'b1;
                    last_rise = cyc;
                end
                if (i == h) pwm_in = 1'b0;
                tick();
            end
        end
    endtask

    task automatic clear_counts();
        n_valid   = 0;
        n_ovr     = 0;
        valid_cyc = -1;
    endtask

    initial begin
        rst    = 1'b1;
        pwm_in = 1'b0;
        clear_counts();
        repeat (3) tick();
        check("rst_period", period, 0);
        check("rst_high", high_time, 0);
        check("rst_duty", duty, 0);
        check("rst_valid", valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_timeout", timeout, 0);
        check("rst_level", level, 0);
        rst = 1'b0;
        repeat (5) tick();

        // Square wave 100/25 from reset.
        clear_counts();
        wave(25, 100, 1);
        check("sq_first_no_valid", n_valid, 0);
        wave(25, 100, 1);
        check("sq_valid_count", n_valid, 1);
        check("sq_valid_cycle", valid_cyc, last_rise + 11);
        check("sq_period", v_period, 100);
        check("sq_high", v_high, 25);
        check("sq_duty", v_duty, 64);
        check("sq_period_hold", period, 100);
        wave(25, 100, 1);
        check("sq_repeat_count", n_valid, 2);
        check("sq_repeat_cycle", valid_cyc, last_rise + 11);
        check("sq_no_overrun", n_ovr, 0);

        // Period 20, high 19 (first rise closes the last 100/25 period).
        clear_counts();
        wave(19, 20, 4);
        check("p20_valid_count", n_valid, 4);
        check("p20_valid_cycle", valid_cyc, last_rise + 11);
        check("p20_period", v_period, 20);
        check("p20_high", v_high, 19);
        check("p20_duty", v_duty, 243);
        check("p20_no_overrun", n_ovr, 0);

        // Pin high across reset release: the initial fall must be ignored.
        pwm_in = 1'b1;
        rst    = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        pwm_in = 1'b0;
        repeat (20) tick();
        clear_counts();
        wave(10, 40, 2);
        check("hi_rst_valid_count", n_valid, 1);
        check("hi_rst_valid_cycle", valid_cyc, last_rise + 11);
        check("hi_rst_period", v_period, 40);
        check("hi_rst_high", v_high, 10);
        check("hi_rst_duty", v_duty, 64);

        // Period 6, high 3: accepted and dropped measurements alternate.
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        repeat (5) tick();
        clear_counts();
        wave(3, 6, 8);
        repeat (12) tick();
        check("p6_valid_count", n_valid, 4);
        check("p6_overrun_count", n_ovr, 3);
        check("p6_valid_cycle", valid_cyc, last_rise + 11);
        check("p6_period", v_period, 6);
        check("p6_high", v_high, 3);
        check("p6_duty", v_duty, 128);

        // Timeout with the pin stuck high, then recovery.
        clear_counts();
        wave(50, 100, 3);
        check("pre_to_period", v_period, 100);
        check("pre_to_duty", v_duty, 128);
        pwm_in   = 1'b1;
        rise_p   = cyc;
        tout_cyc = -1;
        tout_lvl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            tick();
            if (timeout === 1'b1 && tout_cyc < 0) begin
                tout_cyc = cyc;
                tout_lvl = level;
            end
        end
        check("to_cycle", tout_cyc, rise_p + 2 + 511);
        check("to_level", tout_lvl, 1);
        check("to_sticky", timeout, 1);
        pwm_in = 1'b0;
        repeat (10) tick();
        clear_counts();
        wave(50, 100, 1);
        check("to_still_set", timeout, 1);
        check("to_resume_no_valid", n_valid, 0);
        wave(50, 100, 1);
        check("to_resume_valid", n_valid, 1);
        check("to_cleared", timeout, 0);
        check("to_resume_period", v_period, 100);
        check("to_resume_high", v_high, 50);
        check("to_resume_duty", v_duty, 128);

        // One-cycle reset in HIGH mid-measurement.
        pwm_in = 1'b1;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        check("mid_rst_period", period, 0);
        check("mid_rst_high", high_time, 0);
        check("mid_rst_duty", duty, 0);
        check("mid_rst_valid", valid, 0);
        check("mid_rst_overrun", overrun, 0);
        check("mid_rst_timeout", timeout, 0);
        check("mid_rst_level", level, 0);
        rst = 1'b0;
        repeat (29) tick();
        pwm_in = 1'b0;
        repeat (50) tick();
        clear_counts();
        wave(30, 100, 1);
        check("post_rst_no_valid", n_valid, 0);
        wave(30, 100, 1);
        check("post_rst_valid", n_valid, 1);
        check("post_rst_cycle", valid_cyc, last_rise + 11);
        check("post_rst_period", v_period, 100);
        check("post_rst_high", v_high, 30);
        check("post_rst_duty", v_duty, 76);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
